// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared state encoding, digit codes and segment patterns
// for the ALU result display.
package alu_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NEG    = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_E     = 4'd11;
  localparam logic [3:0] DIG_BLANK = 4'd15;

  // gfedcba, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational digit code to active-low segment pattern.
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:      seg_o = SEG_0;
      4'd1:      seg_o = SEG_1;
      4'd2:      seg_o = SEG_2;
      4'd3:      seg_o = SEG_3;
      4'd4:      seg_o = SEG_4;
      4'd5:      seg_o = SEG_5;
      4'd6:      seg_o = SEG_6;
      4'd7:      seg_o = SEG_7;
      4'd8:      seg_o = SEG_8;
      4'd9:      seg_o = SEG_9;
      DIG_MINUS: seg_o = SEG_MINUS;
      DIG_E:     seg_o = SEG_E;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to sign/BCD conversion and 4-digit scanned display.
// Optional OVF_BLINK_EN blanks the display periodically while signed overflow is shown.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] result,
  input  logic [1:0] ovf,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int PW = $clog2(SCAN_DIV);

  state_e     state_q;
  logic [5:0] res_q;
  logic [1:0] flg_q;
  logic       neg_q;
  logic [5:0] bin_q;
  logic [7:0] bcd_q;
  logic [2:0] cnt_q;
  logic       busy_q;

  logic [3:0] disp_tens_q;
  logic [3:0] disp_units_q;
  logic       disp_neg_q;
  logic [1:0] disp_flg_q;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;
  logic [13:0] dd_shift;
  logic [7:0]  bcd_d;
  logic [5:0]  bin_d;

  always_comb begin
    tens_adj  = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    units_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    dd_shift  = {tens_adj, units_adj, bin_q} << 1;
    bcd_d     = dd_shift[13:6];
    bin_d     = dd_shift[5:0];
  end

  // A fresh load is also taken in COMMIT so a new conversion can start the
  // same edge the previous one lands on the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      res_q        <= '0;
      flg_q        <= '0;
      neg_q        <= 1'b0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      disp_tens_q  <= '0;
      disp_units_q <= '0;
      disp_neg_q   <= 1'b0;
      disp_flg_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            res_q   <= result;
            flg_q   <= ovf;
            busy_q  <= 1'b1;
            state_q <= ST_NEG;
          end
        end
        ST_NEG: begin
          neg_q   <= res_q[5];
          bin_q   <= res_q[5] ? (~res_q + 6'd1) : res_q;
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_tens_q  <= bcd_q[7:4];
          disp_units_q <= bcd_q[3:0];
          disp_neg_q   <= neg_q && (bcd_q != 8'd0);
          disp_flg_q   <= flg_q;
          if (load) begin
            res_q   <= result;
            flg_q   <= ovf;
            busy_q  <= 1'b1;
            state_q <= ST_NEG;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [3:0] cur_code;
  logic [6:0] cur_seg;

  always_comb begin
    cur_code = DIG_BLANK;
    case (idx_q)
      2'd0: cur_code = disp_units_q;
      2'd1: cur_code = (disp_tens_q == 4'd0) ? DIG_BLANK : disp_tens_q;
      2'd2: cur_code = disp_neg_q ? DIG_MINUS : DIG_BLANK;
      2'd3: cur_code = disp_flg_q[0] ? DIG_E : DIG_BLANK;
      default: cur_code = DIG_BLANK;
    endcase
  end

  seg7_decode u_seg7_decode (
    .code_i(cur_code),
    .seg_o (cur_seg)
  );

  // The digit presented at a terminal count is the current index; the index
  // then advances, so the first digit shown after reset is d0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
      an_q    <= ~(4'b0001 << idx_q);
      seg_q   <= cur_seg;
      dp_q    <= !((idx_q == 2'd0) && disp_flg_q[1]);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

`ifdef OVF_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_q;
  logic          phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (blink_q == BW'(BLINK_DIV - 1)) begin
      blink_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      blink_q <= blink_q + BW'(1);
    end
  end

  assign an = (disp_flg_q[0] && phase_q) ? 4'b1111 : an_q;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_DIV > 0);
  assign an = an_q;
`endif

  assign busy = busy_q;
  assign seg  = seg_q;
  assign dp   = dp_q;

endmodule
